// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receiver FSM encoding, baud divisor helper.
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Clocks per bit; common to the TX and RX sides.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// IO-page view of the UART receiver: pop/clear strobes in, FIFO head and status out.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              i_rstrb;
    logic              i_clr_err;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic [CNT_W-1:0]  o_count;
    logic              o_overrun;
    logic              o_frame_err;

    modport master (
        output i_rstrb, i_clr_err,
        input  o_data, o_valid, o_count, o_overrun, o_frame_err
    );

    modport slave (
        input  i_rstrb, i_clr_err,
        output o_data, o_valid, o_count, o_overrun, o_frame_err
    );
endinterface

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; a pop on a full FIFO makes room for a same-edge push.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned ADDR_W = CNT_W - 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [CNT_W-1:0]  r_wptr;
    logic [CNT_W-1:0]  r_rptr;
    logic              w_pop;
    logic              w_push;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                     (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_count = r_wptr - r_rptr;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr[ADDR_W-1:0]];

    // Pointer update; an empty-FIFO pop is dropped by w_pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + CNT_W'(1);
            if (w_pop)  r_rptr <= r_rptr + CNT_W'(1);
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) r_mem[r_wptr[ADDR_W-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO read from the IO page.
// Optional framing check and break wait: define UART_RX_FRAMING_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rxd,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned DIV    = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned BAUD_W = $clog2(DIV);
    localparam int unsigned BIT_W  = $clog2(DATA_W);

    logic              r_s1;
    logic              r_s2;
    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [BAUD_W-1:0] r_cnt;
    logic [BAUD_W-1:0] w_cnt_nxt;
    logic [BIT_W-1:0]  r_bit_idx;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_tick;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic              w_ov_set;
    logic              r_overrun;
`ifdef UART_RX_FRAMING_EN
    logic              r_brk;
    logic              w_brk_nxt;
    logic              w_fe_set;
    logic              r_frame_err;
`endif

    assign w_tick = (r_cnt == '0);

    // Two-flop synchroniser on the asynchronous RXD pin, idling high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_rxd;
            r_s2 <= r_s1;
        end
    end

    // Receiver state register; a reset drops any partial byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef UART_RX_FRAMING_EN
            r_brk     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
`ifdef UART_RX_FRAMING_EN
            r_brk     <= w_brk_nxt;
`endif
        end
    end

    // Next-state logic: mid-bit sampling driven by the down-counting baud counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_tick ? '0 : r_cnt - BAUD_W'(1);
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
`ifdef UART_RX_FRAMING_EN
        w_brk_nxt   = r_brk;
        w_fe_set    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef UART_RX_FRAMING_EN
                if (r_s2) w_brk_nxt = 1'b0;
                if (!r_s2 && !r_brk) begin
`else
                if (!r_s2) begin
`endif
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = BAUD_W'(DIV / 2 - 1);
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (!r_s2) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = BAUD_W'(DIV - 1);
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {r_s2, r_shift[DATA_W-1:1]};
                    w_bit_nxt   = r_bit_idx + BIT_W'(1);
                    w_cnt_nxt   = BAUD_W'(DIV - 1);
                    if (r_bit_idx == BIT_W'(DATA_W - 1)) w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
`ifdef UART_RX_FRAMING_EN
                    if (r_s2) begin
                        w_push = 1'b1;
                    end else begin
                        w_fe_set  = 1'b1;
                        w_brk_nxt = 1'b1;
                    end
`else
                    w_push = 1'b1;
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (r_shift),
        .i_pop   (bus.i_rstrb),
        .o_rdata (bus.o_data),
        .o_count (bus.o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.o_valid = !w_empty;
    // A full FIFO with a same-edge pop still accepts the byte.
    assign w_ov_set    = w_push && w_full && !bus.i_rstrb;

    // Sticky overrun flag; a new set beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst)              r_overrun <= 1'b0;
        else if (w_ov_set)      r_overrun <= 1'b1;
        else if (bus.i_clr_err) r_overrun <= 1'b0;
    end

    assign bus.o_overrun = r_overrun;

`ifdef UART_RX_FRAMING_EN
    // Sticky framing-error flag; a new set beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst)              r_frame_err <= 1'b0;
        else if (w_fe_set)      r_frame_err <= 1'b1;
        else if (bus.i_clr_err) r_frame_err <= 1'b0;
    end

    assign bus.o_frame_err = r_frame_err;
`else
    assign bus.o_frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue-based reference model checked every cycle.
module tb_uart_rx_fifo;
    localparam int unsigned CLK_HZ = 1000000;
    localparam int unsigned BAUD   = 100000;
    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int unsigned DEPTH  = 4;
    localparam int FRAME_C = 10 * DIV;
    // Edges from the line falling to the push edge: 2 sync + 1 IDLE + half bit + 9 full bits.
    localparam int PUSH_C  = 3 + DIV / 2 + 9 * DIV;
`ifdef UART_RX_FRAMING_EN
    localparam bit FRAMING = 1'b1;
`else
    localparam bit FRAMING = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_rxd = 1'b1;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_rxd (i_rxd),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] m_q [$];
    logic       m_ov = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_push_req  = 1'b0;
    logic [7:0] m_push_byte = 8'h00;
    logic       m_push_stop = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO as a queue, updated on each rising edge.
    initial begin
        bus.i_rstrb   = 1'b0;
        bus.i_clr_err = 1'b0;
        forever begin
            @(posedge i_clk);
            if (i_rst) begin
                m_q.delete();
                m_ov = 1'b0;
                m_fe = 1'b0;
                m_push_req = 1'b0;
            end else begin
                logic ov_set, fe_set, do_push, do_pop;
                ov_set  = 1'b0;
                fe_set  = 1'b0;
                do_push = 1'b0;
                do_pop  = bus.i_rstrb && (m_q.size() > 0);
                if (m_push_req) begin
                    if (FRAMING && !m_push_stop) fe_set = 1'b1;
                    else if (m_q.size() == DEPTH && !do_pop) ov_set = 1'b1;
                    else do_push = 1'b1;
                end
                if (do_pop) void'(m_q.pop_front());
                if (do_push) m_q.push_back(m_push_byte);
                if (bus.i_clr_err) begin
                    m_ov = 1'b0;
                    m_fe = 1'b0;
                end
                if (ov_set) m_ov = 1'b1;
                if (fe_set) m_fe = 1'b1;
                m_push_req = 1'b0;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model, away from the active edge.
    initial begin
        forever begin
            logic [31:0] act, exp;
            logic        ev;
            @(negedge i_clk);
            ev  = (m_q.size() > 0);
            exp = {18'd0, ev, 3'(m_q.size()), (ev ? m_q[0] : 8'h00), m_ov, m_fe};
            act = {18'd0, bus.o_valid, bus.o_count, (bus.o_valid ? bus.o_data : 8'h00),
                   bus.o_overrun, bus.o_frame_err};
            chk("cycle_model", act, exp);
        end
    end

    // Drive one 8N1 frame (or its first ncyc cycles) and announce the push edge to the model.
    task automatic send(input logic [7:0] b, input logic stop, input int ncyc, input logic pop_on_push);
        for (int c = 0; c < ncyc; c++) begin
            int bi;
            @(posedge i_clk); #1;
            bi = c / DIV;
            if (bi == 0)      i_rxd = 1'b0;
            else if (bi <= 8) i_rxd = b[bi-1];
            else              i_rxd = stop;
            if (c == PUSH_C - 1) begin
                m_push_req  = 1'b1;
                m_push_byte = b;
                m_push_stop = stop;
                if (pop_on_push) bus.i_rstrb = 1'b1;
            end
            if (c == PUSH_C && pop_on_push) bus.i_rstrb = 1'b0;
        end
        @(posedge i_clk); #1;
        i_rxd = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, 32'(bus.o_data), 32'(exp));
        bus.i_rstrb = 1'b1;
        @(posedge i_clk); #1;
        bus.i_rstrb = 1'b0;
    endtask

    task automatic clr_err();
        bus.i_clr_err = 1'b1;
        @(posedge i_clk); #1;
        bus.i_clr_err = 1'b0;
    endtask

    initial begin
        repeat (20000) @(posedge i_clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_count", 32'(bus.o_count), 32'd0);
        chk("rst_flags", 32'({bus.o_overrun, bus.o_frame_err}), 32'd0);
        chk("rst_data", 32'(bus.o_data), 32'd0);

        // Single byte
        send(8'h55, 1'b1, FRAME_C, 1'b0);
        chk("t1_valid", 32'(bus.o_valid), 32'd1);
        chk("t1_count", 32'(bus.o_count), 32'd1);
        pop_chk("t1_data", 8'h55);
        chk("t1_empty", 32'({bus.o_valid, bus.o_count}), 32'd0);

        // Glitch on the line
        @(posedge i_clk); #1;
        i_rxd = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rxd = 1'b1;
        repeat (20) @(posedge i_clk);
        #1;
        chk("t2_count", 32'(bus.o_count), 32'd0);
        chk("t2_flags", 32'({bus.o_overrun, bus.o_frame_err}), 32'd0);

        // Overrun
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, FRAME_C, 1'b0);
        chk("t3_count", 32'(bus.o_count), 32'd4);
        chk("t3_overrun", 32'(bus.o_overrun), 32'd1);
        for (int i = 1; i <= 4; i++) pop_chk("t3_pop", 8'(i));
        chk("t3_drained", 32'(bus.o_count), 32'd0);
        chk("t3_ov_sticky", 32'(bus.o_overrun), 32'd1);
        clr_err();
        chk("t3_ov_clr", 32'(bus.o_overrun), 32'd0);

        // Bad stop bit
        send(8'hA3, 1'b0, FRAME_C, 1'b0);
`ifdef UART_RX_FRAMING_EN
        chk("t4_count", 32'(bus.o_count), 32'd0);
        chk("t4_fe", 32'(bus.o_frame_err), 32'd1);
        clr_err();
        chk("t4_fe_clr", 32'(bus.o_frame_err), 32'd0);
`else
        chk("t4_count", 32'(bus.o_count), 32'd1);
        chk("t4_fe", 32'(bus.o_frame_err), 32'd0);
        pop_chk("t4_data", 8'hA3);
`endif

        // Push and pop on the same edge while full
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1, FRAME_C, 1'b0);
        chk("t5_full", 32'(bus.o_count), 32'd4);
        send(8'h14, 1'b1, FRAME_C, 1'b1);
        chk("t5_count", 32'(bus.o_count), 32'd4);
        chk("t5_overrun", 32'(bus.o_overrun), 32'd0);
        for (int i = 1; i <= 4; i++) pop_chk("t5_pop", 8'h10 + 8'(i));

        // Reset mid-frame, then a clean frame
        send(8'hFF, 1'b1, 5 * DIV, 1'b0);
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("t6_count", 32'(bus.o_count), 32'd0);
        chk("t6_valid", 32'(bus.o_valid), 32'd0);
        send(8'h3C, 1'b1, FRAME_C, 1'b0);
        chk("t6_count2", 32'(bus.o_count), 32'd1);
        pop_chk("t6_data", 8'h3C);

        repeat (5) @(posedge i_clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receiver for the SOC's RXD pin, 8N1 format.
- Reassembles bytes and buffers them in a small FIFO.
- Presents the FIFO head and status to the SOC IO decoder, which the CPU reads by load from the IO page.
- This is the receive-side counterpart of the UART emitter on TXD and shares its baud-rate parameterisation.

Parameters:
- CLK_FREQ_HZ, 12000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate. DIV = CLK_FREQ_HZ/BAUD_RATE, integer division; DIV must be >= 4.
- FIFO_DEPTH, 4, number of byte entries; power of 2, >= 2.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_rxd  in  1  asynchronous serial input; idles high.
- i_rstrb  in  1  pop strobe, one cycle per byte consumed.
- i_clr_err  in  1  clears the sticky error flags.
- o_data  out  8  FIFO head byte; valid only while o_valid=1.
- o_valid  out  1  FIFO non-empty.
- o_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- o_overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- o_frame_err  out  1  sticky framing error (see Optional Feature).

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous, active-high.
- Reset values:
  - FSM goes to IDLE; FIFO is emptied.
  - o_valid=0, o_count=0, o_overrun=0, o_frame_err=0, o_data=0.
  - Both synchroniser flops are set to 1.
- Synchroniser: i_rxd passes through a 2-flop synchroniser (rx_s). All FSM decisions use rx_s, so there are 2 cycles of input latency.
- Baud counter: counts down and is reloaded per state. A "tick" is the counter reaching 0.
- IDLE:
  - rx_s=0 → START, counter=DIV/2-1.
- START, at tick (mid start bit):
  - rx_s=0 → DATA, counter=DIV-1, bit index=0.
  - rx_s=1 → IDLE (glitch rejected, nothing pushed).
- DATA, at each tick:
  - Sample rx_s into the shift register LSB-first: shift right, insert at bit 7.
  - Increment bit index and reload counter=DIV-1.
  - After the 8th sample → STOP.
- STOP, at tick (mid stop bit):
  - Evaluate the stop bit.
  - Issue a push request.
  - Go to IDLE. There is no wait for the line to return high beyond that sample.
  - A start edge is accepted on the next cycle.
- Push timing: the push takes effect on the cycle after the stop-bit tick. o_valid/o_count update on that same edge.
- FIFO storage and pointers:
  - Register array with read/write pointers of $clog2(FIFO_DEPTH)+1 bits.
  - Pointers wrap naturally. Full when the MSBs differ and the low bits are equal.
- FIFO read port: o_data is a combinational read of the head entry; zero read latency.
- Pop: i_rstrb with o_valid=1 pops on that edge. i_rstrb when empty is ignored: no underflow, no flag.
- Push while full with no pop: the new byte is discarded, o_overrun←1, existing contents are unchanged.
- Push and pop on the same edge:
  - When full: the pop frees a slot, so the push is accepted, o_count is unchanged and no overrun is raised.
  - When empty: the push is written and the pop is ignored, so o_count=1.
- Error flags:
  - i_clr_err clears both flags.
  - If a set condition coincides with i_clr_err, set wins.
- Reset mid-frame: the partial byte is discarded and no flag is raised.

Optional Feature:
- Macro: UART_RX_FRAMING_EN.
- Defined:
  - A stop sample of 0 suppresses the push and sets o_frame_err.
  - The FSM returns to IDLE but waits for rx_s=1 before accepting a new start, so a break condition is not re-read as a start.
- Undefined:
  - The byte is pushed regardless of the stop-bit value.
  - o_frame_err is tied to 0.
  - There is no break wait.

Decomposition:
- Package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP).
  - Divisor computation function, shared with the TX side.
  - Data width constant (8).
- Sub-module byte_fifo:
  - Parameter FIFO_DEPTH; push/pop/data/count/full/empty.
  - Implements the simultaneous push/pop rules above.
  - Reusable later for a TX-side buffer in front of the emitter.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000000, BAUD_RATE=100000 (DIV=10), FIFO_DEPTH=4.
1. Single byte: drive 0x55 as 8N1.
   - One cycle after the stop-bit tick: o_valid=1, o_data=0x55, o_count=1.
   - 1-cycle i_rstrb → o_valid=0, o_count=0.
2. Glitch: i_rxd low for 3 cycles, then high.
   - FSM returns to IDLE; o_count stays 0; no flags.
3. Overrun: send 0x01..0x05 with no pops.
   - o_count=4, o_overrun=1, o_data=0x01.
   - Four pops return 0x01..0x04 in order.
   - i_clr_err → o_overrun=0.
4. Framing: send 0xA3 with stop bit driven 0.
   - Macro defined: no push, o_frame_err=1.
   - Undefined: 0xA3 pushed, o_frame_err=0.
5. Simultaneous push/pop: FIFO holds 0x10..0x13; assert i_rstrb on the push edge of 0x14.
   - o_count stays 4, o_overrun=0.
   - Subsequent pops yield 0x11,0x12,0x13,0x14.
6. Reset mid-frame: assert i_rst after the 4th data bit of 0xFF.
   - FSM is in IDLE, o_count=0.
   - Next frame 0x3C is received correctly.
